// File: rtl/bus_mem_responder.sv
// Word-addressed memory responder with byte-masked writes, fixed-latency reads,
// a sticky out-of-range flag and an optional post-accept stall on ready_o.
module bus_mem_responder #(
    parameter int AddrWidth   = 64,
    parameter int DataWidth   = 64,
    parameter int Depth       = 1024,
    parameter int Latency     = 2,
    parameter int StallCycles = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wmask_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   rvalid_o,
    output logic                   oob_o
);

    localparam int NumBytes = DataWidth / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int IdxW     = $clog2(Depth);
    localparam int CntW     = (StallCycles > 0) ? $clog2(StallCycles + 1) : 1;

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    logic [DataWidth-1:0] mem_q [Depth];

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                oob_q;
    logic                pipe_vld_q [Latency];
    logic [DataWidth-1:0] pipe_dat_q [Latency];

    logic                accept_s;
    logic                is_write_s;
    logic                oob_s;
    logic [IdxW-1:0]     idx_s;
    logic [DataWidth-1:0] rd_word_s;

    // Request decode; any address bit above the word index marks out of range.
    assign accept_s   = valid_i && ready_q && !rst_i;
    assign is_write_s = (wmask_i != {NumBytes{1'b0}});
    assign oob_s      = ((addr_i >> (OffW + IdxW)) != {AddrWidth{1'b0}});
    assign idx_s      = addr_i[OffW +: IdxW];
    assign rd_word_s  = oob_s ? {DataWidth{1'b0}} : mem_q[idx_s];

    // Storage is deliberately left unreset; only in-range accepted writes touch it.
    always_ff @(posedge clk_i) begin
        if (accept_s && is_write_s && !oob_s) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (wmask_i[b]) begin
                    mem_q[idx_s][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Ready FSM state register; ready_o is registered so it never follows valid_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_READY;
            cnt_q   <= {CntW{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Ready FSM next state: each accept buys StallCycles cycles of ready_o low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY: begin
                if (accept_s && (StallCycles > 0)) begin
                    state_d = ST_STALL;
                    cnt_d   = CntW'(StallCycles);
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_STALL: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = ST_READY;
                    cnt_d   = {CntW{1'b0}};
                end else begin
                    cnt_d   = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = {CntW{1'b0}};
            end
        endcase
        ready_d = (state_d == ST_READY);
    end

    // Read pipeline: stage 0 loads at the accept edge, last stage drives the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < Latency; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_dat_q[k] <= {DataWidth{1'b0}};
            end
        end else begin
            pipe_vld_q[0] <= accept_s && !is_write_s;
            pipe_dat_q[0] <= (accept_s && !is_write_s) ? rd_word_s : {DataWidth{1'b0}};
            for (int k = 1; k < Latency; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_dat_q[k] <= pipe_dat_q[k-1];
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oob_q <= 1'b0;
        end else if (accept_s && oob_s) begin
            oob_q <= 1'b1;
        end else begin
            oob_q <= oob_q;
        end
    end

    assign ready_o  = ready_q;
    assign rvalid_o = pipe_vld_q[Latency-1];
    assign rdata_o  = pipe_dat_q[Latency-1];
    assign oob_o    = oob_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: a default instance for data/latency
// behaviour and a StallCycles=3 instance for the ready_o pattern.
module tb_bus_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [63:0] addr = 64'h0;
    logic [63:0] wdata = 64'h0;
    logic [7:0]  wmask = 8'h0;
    logic [63:0] rdata;
    logic        rvalid;
    logic        oob;

    logic        valid_s = 1'b0;
    logic        ready_s;
    logic [63:0] addr_s = 64'h0;
    logic [63:0] wdata_s = 64'h0;
    logic [7:0]  wmask_s = 8'h0;
    logic [63:0] rdata_s;
    logic        rvalid_s;
    logic        oob_s;

    exp_t        sb[$];
    logic [63:0] model [DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(.AddrWidth(64), .DataWidth(64), .Depth(DEPTH), .Latency(LAT), .StallCycles(0)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata), .rvalid_o(rvalid), .oob_o(oob)
    );

    bus_mem_responder #(.AddrWidth(64), .DataWidth(64), .Depth(DEPTH), .Latency(LAT), .StallCycles(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_s), .ready_o(ready_s), .addr_i(addr_s),
        .wdata_i(wdata_s), .wmask_i(wmask_s), .rdata_o(rdata_s), .rvalid_o(rvalid_s), .oob_o(oob_s)
    );

    // Advance one clock and compare the response port against the scoreboard.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: rvalid=1 data=%h at cycle %0d, no read pending", rdata, cyc);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read_resp: got data=%h at cycle %0d, expected data=%h at cycle %0d",
                             rdata, cyc, e.data, e.due);
                end
            end
        end else if (rvalid !== 1'b0 || rdata !== 64'h0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
            errors++;
            $display("FAIL idle_output: rvalid=%b rdata=%h pending=%0d at cycle %0d, expected rvalid=0 rdata=0 and no overdue read",
                     rvalid, rdata, sb.size(), cyc);
        end
    endtask

    task automatic req(input logic v, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        exp_t       e;
        logic [9:0] idx;
        logic       oob_a;
        valid = v;
        addr  = a;
        wdata = d;
        wmask = m;
        idx   = a[3 +: 10];
        oob_a = (a[63:13] != 51'h0);
        if (v && ready === 1'b1 && !rst) begin
            if (m == 8'h0) begin
                e.data = oob_a ? 64'h0 : model[idx];
                e.due  = cyc + LAT;
                sb.push_back(e);
            end else if (!oob_a) begin
                for (int b = 0; b < 8; b++) begin
                    if (m[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
        cycle();
        valid = 1'b0;
        wmask = 8'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        valid = 1'b0;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            cycle();
            checks++;
            if (ready !== 1'b0 || oob !== 1'b0 || ready_s !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b oob=%b ready_s=%b, expected 0 0 0", ready, oob, ready_s);
            end
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (ready !== 1'b1 || ready_s !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%b ready_s=%b, expected 1 1", ready, ready_s);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_reset: oob=%b, expected 0", oob);
        end
    endtask

    task automatic test_write_read();
        req(1'b1, 64'h40, 64'h1122334455667788, 8'hFF);
        req(1'b1, 64'h40, 64'h0, 8'h00);
        idle(LAT + 2);
    endtask

    task automatic test_mask();
        req(1'b1, 64'h8, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        req(1'b1, 64'h8, 64'h0000_0000_0000_00BB, 8'h01);
        req(1'b1, 64'h8, 64'h0, 8'h00);
        req(1'b1, 64'h0C, 64'h5555_6666_7777_8888, 8'hF0);
        req(1'b1, 64'hF, 64'h0, 8'h00);
        idle(LAT + 2);
    endtask

    task automatic test_back_to_back();
        req(1'b1, 64'h00, 64'h0101_0101_0101_0101, 8'hFF);
        req(1'b1, 64'h08, 64'h0202_0202_0202_0202, 8'hFF);
        req(1'b1, 64'h10, 64'h0303_0303_0303_0303, 8'hFF);
        req(1'b1, 64'h18, 64'h0404_0404_0404_0404, 8'hFF);
        req(1'b1, 64'h00, 64'h0, 8'h00);
        req(1'b1, 64'h08, 64'h0, 8'h00);
        req(1'b1, 64'h10, 64'h0, 8'h00);
        req(1'b1, 64'h18, 64'h0, 8'h00);
        idle(LAT + 2);
    endtask

    task automatic test_oob();
        req(1'b1, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        checks++;
        if (oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_before: oob=%b, expected 0", oob);
        end
        req(1'b1, 64'h2000, 64'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oob !== 1'b1) begin
                errors++;
                $display("FAIL oob_sticky: oob=%b, expected 1", oob);
            end
            cycle();
        end
        req(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        req(1'b1, 64'h0, 64'h0, 8'h00);
        idle(LAT + 2);
        do_reset(1);
        checks++;
        if (oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_cleared: oob=%b, expected 0", oob);
        end
    endtask

    task automatic test_reset_inflight();
        req(1'b1, 64'h40, 64'h0, 8'h00);
        do_reset(1);
        idle(LAT + 2);
    endtask

    task automatic test_stall();
        int acc;
        acc     = 0;
        valid_s = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ready_s !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL stall_pattern: ready_s=%b at step %0d, expected %b", ready_s, i, ((i % 4) == 0));
            end
            if (ready_s === 1'b1) acc++;
            cycle();
        end
        valid_s = 1'b0;
        checks++;
        if (acc != 3) begin
            errors++;
            $display("FAIL stall_accepts: %0d accepts in 12 cycles, expected 3", acc);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mask();
        test_back_to_back();
        test_oob();
        test_reset_inflight();
        test_stall();
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL dropped_reads: %0d reads never answered, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 The module SHALL have parameter AddrWidth, default 64, meaning request address width in bits.
REQ-002 The module SHALL have parameter DataWidth, default 64, meaning data width in bits, a power of two ≥ 8.
REQ-003 The module SHALL have parameter Depth, default 1024, meaning number of DataWidth-bit words stored, a power of two.
REQ-004 The module SHALL have parameter Latency, default 2, meaning read response latency in cycles, ≥ 1.
REQ-005 The module SHALL have parameter StallCycles, default 0, meaning ready_o low cycles inserted after each accepted request.
REQ-006 The module SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The module SHALL have port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-008 The module SHALL have port valid_i, input, 1 bit, request valid.
REQ-009 The module SHALL have port ready_o, output, 1 bit, responder can accept a request.
REQ-010 The module SHALL have port addr_i, input, AddrWidth bits, byte address.
REQ-011 The module SHALL have port wdata_i, input, DataWidth bits, write data.
REQ-012 The module SHALL have port wmask_i, input, DataWidth/8 bits, byte write enables; all-zero means read.
REQ-013 The module SHALL have port rdata_o, output, DataWidth bits, read response data.
REQ-014 The module SHALL have port rvalid_o, output, 1 bit, rdata_o valid for one cycle.
REQ-015 The module SHALL have port oob_o, output, 1 bit, sticky out-of-range access flag.

Function
REQ-016 A request SHALL be accepted on a rising edge where valid_i && ready_o; at most one per cycle.
REQ-017 The word index SHALL be addr_i[log2(DataWidth/8) +: log2(Depth)]; low log2(DataWidth/8) bits ignored.
REQ-018 An address SHALL be out of range when any addr_i bit above the index field is 1.
REQ-019 An accepted write (wmask_i != 0) in range SHALL update byte i of the indexed word iff wmask_i[i], at the accept edge; no response.
REQ-020 An accepted read in range SHALL capture the word as of before that edge and assert rvalid_o with that data exactly Latency cycles after acceptance (Latency=1: cycle immediately after accept edge).
REQ-021 Reads SHALL be answered in acceptance order; back-to-back reads SHALL give back-to-back rvalid_o pulses; no read is dropped.
REQ-022 A read accepted the cycle after a write to the same word SHALL return the written bytes.
REQ-023 Out-of-range writes SHALL not modify memory; out-of-range reads SHALL respond normally with rdata_o = 0; both SHALL set oob_o = 1 from the next cycle until reset.
REQ-024 rdata_o SHALL be 0 in cycles where rvalid_o = 0.
REQ-025 Ready FSM: state READY (ready_o = 1) and STALL (ready_o = 0, down-counter); on accept with StallCycles > 0, go to STALL with count = StallCycles; leave STALL to READY after exactly StallCycles cycles.
REQ-026 With StallCycles = 0, ready_o SHALL stay 1 every cycle outside reset.
REQ-027 ready_o SHALL not depend combinationally on valid_i.

Reset
REQ-028 While rst_i = 1 at an edge: ready_o = 0, rvalid_o = 0, rdata_o = 0, oob_o = 0, FSM = READY with counter 0, and in-flight reads discarded with no response.
REQ-029 Memory contents SHALL not be reset; read of a never-written word returns undefined data.
REQ-030 ready_o SHALL be 1 in the first cycle after the edge where rst_i is sampled 0.

Verification
REQ-031 Latency=2: write 0x1122334455667788 mask 0xFF to addr 0x40, then read 0x40 -> rvalid_o high exactly 2 cycles after read accept, rdata_o = 0x1122334455667788.
REQ-032 Write 0xAAAA...AA full mask then 0x00000000000000BB mask 0x01 to addr 0x8, read -> rdata_o = 0xAAAAAAAAAAAAAABB.
REQ-033 Four back-to-back reads to 0x0, 0x8, 0x10, 0x18 with distinct contents -> four consecutive rvalid_o pulses, data in order.
REQ-034 StallCycles=3, valid_i held high -> ready_o pattern 1,0,0,0,1,... one accept per 4 cycles.
REQ-035 Depth=1024, DataWidth=64: read addr 0x2000 -> rvalid_o with rdata_o = 0, oob_o = 1 until reset; word 0 unchanged.
REQ-036 Assert rst_i for one cycle while a read is in flight -> no rvalid_o pulse, all outputs 0 during reset, ready_o = 1 the next cycle.
